dat_rx_phys: RTL
================

// Module: dat_rx_phys
// PURPOSE
// - SD DAT-line receive physical layer (card -> host), the read counterpart of the DAT write path.
// - Samples 4-bit DAT bus on sd_clk, detects start bit, packs nibbles MSB-first into FIFO words and writes them to the Rx FIFO.
// - Per block: runs per-lane CRC16 check and end-bit check; repeats for block_cnt blocks; flags completion and errors to the DAT control block.
// PARAMETERS
// - FIFO_WIDTH       32   Rx FIFO word width; multiple of 4.
// - BLOCK_SZ_WIDTH   12   width of block_sz (bytes per block).
// - BLOCK_CNT_WIDTH  16   width of block_cnt.
// - TIMEOUT          1024 max sd_clk cycles waiting for a start bit per block.
// PORTS
// - sd_clk          in   1                the one clock; all logic on its rising edge.
// - rst_L           in   1                reset: synchronous, active-low.
// - DAT_din         in   4                DAT[3:0] from card; DAT[3] = MSB of each nibble.
// - block_sz        in   BLOCK_SZ_WIDTH   bytes per block; latched at start.
// - block_cnt       in   BLOCK_CNT_WIDTH  blocks to receive; latched at start.
// - read_flag       in   1                level; starts a transfer when seen in IDLE.
// - rx_buf_full     in   1                Rx FIFO full.
// - rx_buf_wr_enb   out  1                one-cycle write strobe to Rx FIFO.
// - rx_buf_din_out  out  FIFO_WIDTH       word written; valid while rx_buf_wr_enb = 1.
// - dat_rx_busy     out  1                state != IDLE (combinational from state reg).
// - tf_finished     out  1                one-cycle pulse: transfer ended (ok or error).
// - crc_err         out  1                sticky: CRC or end-bit mismatch in any block.
// - timeout_err     out  1                sticky: no start bit within TIMEOUT.
// - overrun_err     out  1                sticky: word dropped because rx_buf_full.
// BEHAVIOUR
// - Reset (rst_L=0 at edge): state IDLE, every output and internal counter 0. Applies mid-transfer; partial word discarded.
// - States: IDLE, WAIT_START, DATA, CRC, END.
// - IDLE: on read_flag=1, latch block_sz/block_cnt, clear the three error flags, clear CRCs, go to WAIT_START.
//   - If block_cnt==0 or block_sz==0: go to IDLE instead and pulse tf_finished next cycle; no writes.
// - WAIT_START: start bit = DAT_din==4'b0000; other values keep waiting.
//   - Timeout counter increments per cycle; reaching TIMEOUT sets timeout_err, pulses tf_finished, goes to IDLE.
//   - On start bit go to DATA.
// - DATA: one nibble per cycle, 2*block_sz nibbles total.
//   - First nibble of each word goes to [FIFO_WIDTH-1 -: 4].
//   - Each DAT[i] bit is fed to CRC lane i.
// - Word write: rx_buf_wr_enb pulses the cycle after the last nibble of a word is sampled (1-cycle latency).
//   - Final partial word is zero-padded in the LSBs and written the cycle after the last data nibble.
//   - If rx_buf_full at write time: no strobe, word dropped, overrun_err=1, transfer continues.
// - CRC: 16 cycles. Each lane's received bit is compared MSB-first with its computed CRC16 (poly x^16+x^12+x^5+1, 16'h1021, init 0).
//   - Any mismatch sets crc_err.
// - END: DAT_din must be 4'b1111, else crc_err=1.
//   - Decrement remaining count, clear CRCs.
//   - If remaining > 0: go to WAIT_START with timeout counter reset.
//   - Else: go to IDLE and pulse tf_finished in the same cycle as the state change.
// - Data is still delivered on CRC error; the control block decides the response.
// - read_flag changes after start are ignored; only rst_L aborts.
// - Widths: nibble counter is BLOCK_SZ_WIDTH+1 bits (2*block_sz); block counter wraps never (stops at 0).
// STRUCTURE
// - Shared package (defines.v): FIFO_WIDTH, BLOCK_SZ_WIDTH, BLOCK_CNT_WIDTH, CRC16 poly 16'h1021, state encodings (one-hot, 5 bits).
// - Sub-module sd_crc16_lane: serial CRC16 with inputs clr, en, din and output crc[15:0]; instantiated x4.
// - Top level: registered FSM + next-state always block; nibble shifter; counters.
// TESTING
// - block_sz=8, block_cnt=1; start, nibbles 0..F, valid CRCs, end 4'hF
//   -> writes 32'h01234567 then 32'h89ABCDEF; tf_finished 1 cycle; crc_err=0.
// - Same as above with one CRC bit flipped on DAT[2]
//   -> both words still written; crc_err=1 at tf_finished.
// - block_cnt=3, block_sz=4, 5 idle cycles between blocks
//   -> 3 writes; single tf_finished after third end bit; dat_rx_busy high throughout.
// - TIMEOUT=64, DAT_din held 4'hF
//   -> timeout_err=1 and tf_finished after 64 cycles in WAIT_START; no writes; back to IDLE.
// - block_sz=6, data 0xAABBCCDDEEFF
//   -> writes 32'hAABBCCDD then 32'hEEFF0000.
// - rx_buf_full=1 during the first word write -> that word dropped, overrun_err=1.
//   Then rst_L=0 mid-DATA -> next edge: IDLE, all outputs 0.

Source files
------------

// File: rtl/dat_rx_phys_pkg.sv
// Shared constants, state encoding and CRC16 step function for the SD DAT receive path.
package dat_rx_phys_pkg;

   localparam int unsigned FIFO_WIDTH      = 32;
   localparam int unsigned BLOCK_SZ_WIDTH  = 12;
   localparam int unsigned BLOCK_CNT_WIDTH = 16;
   localparam int unsigned NIB_PER_WORD    = FIFO_WIDTH / 4;
   localparam int unsigned NIB_IDX_WIDTH   = $clog2(NIB_PER_WORD);
   localparam logic [15:0] CRC16_POLY      = 16'h1021;

   typedef enum logic [4:0] {
      StIdle      = 5'b00001,
      StWaitStart = 5'b00010,
      StData      = 5'b00100,
      StCrc       = 5'b01000,
      StEnd       = 5'b10000
   } rx_state_e;

   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
      return {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC16_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/dat_rx_phys_if.sv
// DAT receive bus: card data and transfer setup in, Rx FIFO write and status out.
interface dat_rx_phys_if;
   import dat_rx_phys_pkg::*;

   logic [3:0]                 DAT_din;
   logic [BLOCK_SZ_WIDTH-1:0]  block_sz;
   logic [BLOCK_CNT_WIDTH-1:0] block_cnt;
   logic                       read_flag;
   logic                       rx_buf_full;
   logic                       rx_buf_wr_enb;
   logic [FIFO_WIDTH-1:0]      rx_buf_din_out;
   logic                       dat_rx_busy;
   logic                       tf_finished;
   logic                       crc_err;
   logic                       timeout_err;
   logic                       overrun_err;

   modport master (
      input  DAT_din, block_sz, block_cnt, read_flag, rx_buf_full,
      output rx_buf_wr_enb, rx_buf_din_out, dat_rx_busy, tf_finished, crc_err, timeout_err,
             overrun_err
   );

   modport slave (
      output DAT_din, block_sz, block_cnt, read_flag, rx_buf_full,
      input  rx_buf_wr_enb, rx_buf_din_out, dat_rx_busy, tf_finished, crc_err, timeout_err,
             overrun_err
   );

endinterface

// File: rtl/dat_rx_phys_crc16_lane.sv
// Serial CRC16 (x^16+x^12+x^5+1, init 0) for one DAT lane; clr has priority over en.
module dat_rx_phys_crc16_lane
   import dat_rx_phys_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic        din_i,
   output logic [15:0] crc_o
);

   logic [15:0] crc_d, crc_q;

   always_comb begin
      crc_d = crc_q;
      if (clr_i) begin
         crc_d = '0;
      end else if (en_i) begin
         crc_d = crc16_step(crc_q, din_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/dat_rx_phys.sv
// SD DAT-line receiver: start-bit detect, nibble packing into FIFO words, per-lane CRC16 and
// end-bit checks over block_cnt blocks, with completion and sticky error reporting.
module dat_rx_phys
   import dat_rx_phys_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1024
) (
   input logic           sd_clk,
   input logic           rst_L,
   dat_rx_phys_if.master bus
);

   localparam int unsigned TMO_WIDTH = $clog2(TIMEOUT + 1);

   rx_state_e                  state_q, state_d;
   logic [BLOCK_SZ_WIDTH-1:0]  bsz_q, bsz_d;
   logic [BLOCK_CNT_WIDTH-1:0] blk_rem_q, blk_rem_d;
   logic [BLOCK_SZ_WIDTH:0]    nib_cnt_q, nib_cnt_d;
   logic [NIB_IDX_WIDTH-1:0]   wnib_q, wnib_d;
   logic [3:0]                 crc_cnt_q, crc_cnt_d;
   logic [TMO_WIDTH-1:0]       tmo_q, tmo_d;
   logic [FIFO_WIDTH-1:0]      word_q, word_d;
   logic wr_q, wr_d, tf_q, tf_d;
   logic crc_err_q, crc_err_d, tmo_err_q, tmo_err_d, ovr_q, ovr_d;
   logic crc_clr, crc_en, lane_mismatch, nib_last, word_last;
   logic [15:0] lane_crc [4];

   for (genvar i = 0; i < 4; i++) begin : g_lane
      dat_rx_phys_crc16_lane u_lane (
         .clk_i  (sd_clk),
         .rst_ni (rst_L),
         .clr_i  (crc_clr),
         .en_i   (crc_en),
         .din_i  (bus.DAT_din[i]),
         .crc_o  (lane_crc[i])
      );
   end

   assign nib_last  = ((nib_cnt_q + 1'b1) == {bsz_q, 1'b0});
   assign word_last = (wnib_q == NIB_IDX_WIDTH'(NIB_PER_WORD - 1));

   // CRC is sent MSB-first, so cycle k of the CRC phase carries bit 15-k of each lane.
   always_comb begin
      lane_mismatch = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (bus.DAT_din[i] != lane_crc[i][~crc_cnt_q]) begin
            lane_mismatch = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      bsz_d     = bsz_q;
      blk_rem_d = blk_rem_q;
      nib_cnt_d = nib_cnt_q;
      wnib_d    = wnib_q;
      crc_cnt_d = crc_cnt_q;
      tmo_d     = tmo_q;
      word_d    = word_q;
      wr_d      = 1'b0;
      tf_d      = 1'b0;
      crc_err_d = crc_err_q;
      tmo_err_d = tmo_err_q;
      ovr_d     = ovr_q;
      crc_clr   = 1'b0;
      crc_en    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.read_flag) begin
               bsz_d     = bus.block_sz;
               blk_rem_d = bus.block_cnt;
               crc_err_d = 1'b0;
               tmo_err_d = 1'b0;
               ovr_d     = 1'b0;
               crc_clr   = 1'b1;
               tmo_d     = '0;
               if (bus.block_sz == '0 || bus.block_cnt == '0) begin
                  tf_d = 1'b1;
               end else begin
                  state_d = StWaitStart;
               end
            end
         end
         StWaitStart: begin
            if (bus.DAT_din == 4'b0000) begin
               state_d   = StData;
               nib_cnt_d = '0;
               wnib_d    = '0;
            end else if (tmo_q == TMO_WIDTH'(TIMEOUT - 1)) begin
               tmo_err_d = 1'b1;
               tf_d      = 1'b1;
               state_d   = StIdle;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         StData: begin
            crc_en = 1'b1;
            // First nibble of a word clears the rest, so a short final word is zero-padded.
            word_d = ((wnib_q == '0) ? '0 : word_q)
                   | ({bus.DAT_din, {(FIFO_WIDTH - 4){1'b0}}} >> {wnib_q, 2'b00});
            nib_cnt_d = nib_cnt_q + 1'b1;
            wnib_d    = word_last ? '0 : wnib_q + 1'b1;
            if (word_last || nib_last) begin
               if (bus.rx_buf_full) begin
                  ovr_d = 1'b1;
               end else begin
                  wr_d = 1'b1;
               end
            end
            if (nib_last) begin
               state_d   = StCrc;
               crc_cnt_d = '0;
            end
         end
         StCrc: begin
            if (lane_mismatch) begin
               crc_err_d = 1'b1;
            end
            crc_cnt_d = crc_cnt_q + 1'b1;
            if (crc_cnt_q == 4'd15) begin
               state_d = StEnd;
            end
         end
         StEnd: begin
            if (bus.DAT_din != 4'b1111) begin
               crc_err_d = 1'b1;
            end
            crc_clr   = 1'b1;
            tmo_d     = '0;
            blk_rem_d = blk_rem_q - 1'b1;
            if (blk_rem_q == BLOCK_CNT_WIDTH'(1)) begin
               state_d = StIdle;
               tf_d    = 1'b1;
            end else begin
               state_d = StWaitStart;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge sd_clk) begin
      if (!rst_L) begin
         state_q   <= StIdle;
         bsz_q     <= '0;
         blk_rem_q <= '0;
         nib_cnt_q <= '0;
         wnib_q    <= '0;
         crc_cnt_q <= '0;
         tmo_q     <= '0;
         word_q    <= '0;
         wr_q      <= 1'b0;
         tf_q      <= 1'b0;
         crc_err_q <= 1'b0;
         tmo_err_q <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bsz_q     <= bsz_d;
         blk_rem_q <= blk_rem_d;
         nib_cnt_q <= nib_cnt_d;
         wnib_q    <= wnib_d;
         crc_cnt_q <= crc_cnt_d;
         tmo_q     <= tmo_d;
         word_q    <= word_d;
         wr_q      <= wr_d;
         tf_q      <= tf_d;
         crc_err_q <= crc_err_d;
         tmo_err_q <= tmo_err_d;
         ovr_q     <= ovr_d;
      end
   end

   assign bus.rx_buf_wr_enb  = wr_q;
   assign bus.rx_buf_din_out = word_q;
   assign bus.dat_rx_busy    = (state_q != StIdle);
   assign bus.tf_finished    = tf_q;
   assign bus.crc_err        = crc_err_q;
   assign bus.timeout_err    = tmo_err_q;
   assign bus.overrun_err    = ovr_q;

endmodule
